branch_cond_unit: RTL
=====================

Name: branch_cond_unit

Overview:
- Consumer end of the condition-code path: the shifter and ALU produce results and a 4-bit cond vector {S,Z,C,V}; this block latches that vector and resolves branches against it.
- Holds the architectural flag register.
- Evaluates B/BE/BLT/BLE/BNE requests and computes the PC-relative target.
- Presents a registered redirect to the fetch stage with a valid/ready handshake.
- Keeps a saturating taken-branch counter for debug.

Parameters:
- FWD, 1, 1 = a flag write and a branch request in the same cycle make the branch use the new flags; 0 = the branch uses the stored (old) flags.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flag_we  input  1  load flag_in into the flag register this cycle.
- flag_in  input  4  {S,Z,C,V}: bit3 sign, bit2 zero, bit1 carry, bit0 overflow, as produced by shifter/ALU.
- br_valid  input  1  branch request present.
- br_ready  output  1  unit can accept a request this cycle.
- br_uncond  input  1  1 = unconditional B; br_cc is ignored.
- br_cc  input  2  0 BE, 1 BLT, 2 BLE, 3 BNE.
- br_pc  input  16  PC of the branch instruction.
- br_disp  input  8  signed displacement.
- flush  input  1  synchronous kill of any held redirect.
- redir_valid  output  1  redirect outcome held.
- redir_ready  input  1  fetch accepts the redirect.
- redir_taken  output  1  branch taken.
- redir_target  output  16  next PC.
- flags_q  output  4  current flag register.
- taken_cnt  output  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (asynchronous, rst_n=0): flags_q=0, redir_valid=0, redir_taken=0, redir_target=0, taken_cnt=0. br_ready=1 immediately after reset release.
- Flag register: on a rising edge with flag_we=1, flags_q <= flag_in. Otherwise flags_q holds.
- Effective flags feff:
  - FWD=1 and flag_we=1: feff = flag_in.
  - Otherwise: feff = flags_q.
- Condition evaluation, with S=feff[3], Z=feff[2], V=feff[0]:
  - BE: taken = Z.
  - BLT: taken = S^V.
  - BLE: taken = Z | (S^V).
  - BNE: taken = ~Z.
  - br_uncond=1: taken = 1.
  - The C flag is stored but not used by any branch type.
- Target arithmetic:
  - Taken: target = br_pc + 1 + sign_extend16(br_disp), truncated mod 2^16. Wrap-around is silent; e.g. pc=16'hFFFF, disp=0 gives 16'h0000.
  - Not taken: target = br_pc + 1, also mod 2^16.
- Handshake:
  - br_ready = ~redir_valid | redir_ready (combinational).
  - A request is accepted when br_valid & br_ready.
  - Acceptance loads redir_taken and redir_target and sets redir_valid on the next edge, giving 1-cycle latency.
  - redir_valid, redir_taken and redir_target are held stable while redir_valid=1 and redir_ready=0.
  - redir_valid clears on redir_ready unless a new request is accepted in the same cycle. Back-to-back acceptance therefore sustains 1 branch/cycle.
- Counter: taken_cnt increments by 1 on each accepted request with taken=1. It saturates at all-ones and never wraps. Not-taken branches do not change it.
- Flush:
  - flush=1 clears redir_valid on the next edge, and no request is accepted that cycle.
  - br_ready is forced to 0 while flush=1.
  - The flag register and taken_cnt are unaffected by flush.
- Simultaneous flag_we and accepted branch: the flag register always updates. The branch decision follows the FWD rule.
- Reset mid-operation clears all state asynchronously. Any held redirect is lost and no output glitches back to the old value after release.
- Cond codes written with any value (including all-ones) are stored verbatim. No consistency checking is performed.

Test Plan:
- Reset: hold rst_n=0 mid-run with redir_valid=1 -> all outputs 0 asynchronously; br_ready=1 after release.
- Flag/cond matrix: flag_in=4'b0100 (Z) written, then BE, BNE, BLE, BLT issued with pc=16'h0010, disp=8'h05 -> taken 1, 0, 1, 0 respectively. Taken target = 16'h0016, not-taken target = 16'h0011. Repeat with 4'b1000 (S only) -> BLT and BLE taken; then 4'b1001 (S,V) -> BLT not taken.
- Forwarding: flags_q=0, same cycle flag_we=1 with flag_in=4'b0100 plus BE.
  - FWD=1 -> taken.
  - FWD=0 -> not taken, and flags_q=4'b0100 afterwards.
- Wrap and negative displacement:
  - B with pc=16'hFFFF, disp=8'h00 -> target 16'h0000.
  - B with pc=16'h0003, disp=8'hFB (-5) -> target 16'hFFFF.
- Backpressure/flush: redir_ready=0 for 3 cycles -> outputs stable and br_ready=0. Then redir_ready=1 plus a new request -> next outcome appears the following cycle. flush while held -> redir_valid=0 next cycle, taken_cnt unchanged.
- Counter saturation: CNT_W=4, issue 20 taken B -> taken_cnt=4'hF. Then a not-taken BNE with Z=1 -> count stays 4'hF.

Source files
------------

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds the {S,Z,C,V} flag register, resolves B/BE/BLT/BLE/BNE,
// and presents a registered PC redirect to fetch over a valid/ready handshake.
module branch_cond_unit #(
  parameter bit          FWD   = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [3:0]       flag_in,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             br_uncond,
  input  logic [1:0]       br_cc,
  input  logic [15:0]      br_pc,
  input  logic [7:0]       br_disp,
  input  logic             flush,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic             redir_taken,
  output logic [15:0]      redir_target,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    CC_BE  = 2'd0,
    CC_BLT = 2'd1,
    CC_BLE = 2'd2,
    CC_BNE = 2'd3
  } cc_e;

  logic [3:0]  feff;
  logic        flag_s, flag_z, flag_v;
  logic        taken;
  logic        accept;
  logic [15:0] seq_pc;
  logic [15:0] disp_ext;
  logic [15:0] target;

  // A full slot can take a new request only if fetch drains it this cycle.
  assign br_ready = (~redir_valid | redir_ready) & ~flush;
  assign accept   = br_valid & br_ready;

  assign feff   = (FWD && flag_we) ? flag_in : flags_q;
  assign flag_s = feff[3];
  assign flag_z = feff[2];
  assign flag_v = feff[0];

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    if (br_uncond) begin
      taken = 1'b1;
    end else begin
      unique case (cc_e'(br_cc))
        CC_BE:   taken = flag_z;
        CC_BLT:  taken = flag_s ^ flag_v;
        CC_BLE:  taken = flag_z | (flag_s ^ flag_v);
        CC_BNE:  taken = ~flag_z;
        default: taken = 1'b0;
      endcase
    end
  end

  // Wrap-around past 16'hFFFF is architecturally silent.
  assign seq_pc   = br_pc + 16'd1;
  assign disp_ext = {{8{br_disp[7]}}, br_disp};
  assign target   = taken ? (seq_pc + disp_ext) : seq_pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'd0;
    end else if (flag_we) begin
      flags_q <= flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_valid  <= 1'b0;
      redir_taken  <= 1'b0;
      redir_target <= 16'd0;
    end else if (flush) begin
      redir_valid <= 1'b0;
    end else if (accept) begin
      redir_valid  <= 1'b1;
      redir_taken  <= taken;
      redir_target <= target;
    end else if (redir_ready) begin
      redir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
    end else if (accept && taken && (taken_cnt != {CNT_W{1'b1}})) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
